// File: rtl/rv_pc_gen_pkg.sv
// Shared front-end definitions: default width, legal instruction alignments
// and the next-PC source encoding used by the PC generator.
package rv_core_pkg;

  localparam int XLEN_DEFAULT      = 32;
  localparam int IALIGN_COMPRESSED = 2;
  localparam int IALIGN_BASE       = 4;

  typedef enum logic [2:0] {
    NPC_TRAP,
    NPC_BRANCH,
    NPC_RAS,
    NPC_SEQ,
    NPC_HOLD
  } npc_src_e;

endpackage

// File: rtl/rv_pc_gen_if.sv
// Fetch request channel between the PC generator (master) and the
// instruction-fetch port (slave).
interface rv_pc_gen_if #(
  parameter int XLEN = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;

  modport master (output fetch_valid, output fetch_pc, input fetch_ready);
  modport slave  (input fetch_valid, input fetch_pc, output fetch_ready);
endinterface

// File: rtl/rv_pc_gen_ras.sv
// Return-address stack: circular buffer with write pointer and saturating
// count. When full, a push overwrites the oldest entry.
module rv_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic            pop,
  input  logic            clear,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_top_idx;
  logic            w_pop;

  assign w_top_idx = r_ptr - PW'(1);
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(RAS_DEPTH));
  assign w_pop     = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push && !w_pop) begin
      r_ptr   <= r_ptr + PW'(1);
      r_count <= full ? r_count : r_count + CW'(1);
    end else if (w_pop && !push) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CW'(1);
    end
  end

  // Push with a simultaneous pop rewrites the current top in place.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      r_mem[w_pop ? w_top_idx : r_ptr] <= push_addr;
    end
  end

endmodule

// File: rtl/rv_pc_gen.sv
// Program-counter generator: PC register, prioritised next-PC mux
// (trap > branch > RAS > sequential > hold), branch alignment check and RAS.
module rv_pc_gen
  import rv_core_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = IALIGN_BASE,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  rv_pc_gen_if.master       fetch,
  input  logic              stall,
  input  logic              inc_sel,
  output logic [XLEN-1:0]   pc_plus_inc,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_vector,
  input  logic              ras_push,
  input  logic [XLEN-1:0]   ras_push_addr,
  input  logic              ras_pop,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              misalign_err,
  output logic [XLEN-1:0]   misalign_addr
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_merr;
  logic [XLEN-1:0] r_maddr;

  logic [XLEN-1:0] w_inc;
  logic [XLEN-1:0] w_npc;
  logic [XLEN-1:0] w_ras_top;
  logic            w_fire;
  logic            w_br_mis;
  logic            w_misalign;
  npc_src_e        w_src;

  assign w_fire      = r_valid & fetch.fetch_ready & ~stall;
  assign w_br_mis    = |(branch_target & ALIGN_MASK);
  assign w_inc       = (IALIGN == IALIGN_COMPRESSED && inc_sel) ? XLEN'(2) : XLEN'(4);
  assign pc_plus_inc = r_pc + w_inc;

  always_comb begin
    w_src      = NPC_HOLD;
    w_misalign = 1'b0;
    if (trap_valid) begin
      w_src = NPC_TRAP;
    end else if (branch_taken) begin
      if (w_br_mis) w_misalign = 1'b1;
      else          w_src      = NPC_BRANCH;
    end else if (w_fire && ras_pop && !ras_empty) begin
      w_src = NPC_RAS;
    end else if (w_fire) begin
      w_src = NPC_SEQ;
    end
  end

  always_comb begin
    w_npc = r_pc;
    case (w_src)
      NPC_TRAP:   w_npc = trap_vector & ~ALIGN_MASK;
      NPC_BRANCH: w_npc = branch_target;
      NPC_RAS:    w_npc = w_ras_top;
      NPC_SEQ:    w_npc = pc_plus_inc;
      default:    w_npc = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RESET_VECTOR;
      r_valid <= 1'b0;
      r_merr  <= 1'b0;
      r_maddr <= '0;
    end else begin
      r_pc    <= w_npc;
      r_valid <= 1'b1;
      r_merr  <= w_misalign;
      if (w_misalign) r_maddr <= branch_target;
    end
  end

  // Only a pop that actually selects the next PC consumes an entry.
  rv_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .push_addr (ras_push_addr),
    .pop       (w_src == NPC_RAS),
    .clear     (trap_valid),
    .top       (w_ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign fetch.fetch_valid = r_valid;
  assign fetch.fetch_pc    = r_pc;
  assign misalign_err      = r_merr;
  assign misalign_addr     = r_maddr;

endmodule
